// File: rtl/alu_flag_unit.sv
// alu_flag_unit: architectural NZCV status register, in-flight flag-setter
// tracking and ARM condition-code evaluation behind a valid/ready handshake.
module alu_flag_unit #(
  parameter int unsigned PEND_W = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flag_issue,
  input  logic              flag_wr,
  input  logic [31:0]       flags_in,
  input  logic              cond_valid,
  input  logic [3:0]        cond,
  output logic              cond_ready,
  output logic              res_valid,
  output logic              res_pass,
  output logic [3:0]        nzcv,
  output logic [PEND_W-1:0] pending,
  output logic              issue_stall,
  output logic              err
);

  localparam logic [PEND_W-1:0] PEND_MAX = '1;

  typedef enum logic {IDLE, WAIT} req_state_t;

  req_state_t        req_state;
  logic [PEND_W-1:0] pend_eff;
  logic [3:0]        nzcv_eff;
  logic              accept;
  logic              cond_pass;
  logic              unused_flags;

  // Only the top nibble of the flags word carries NZCV.
  assign unused_flags = ^flags_in[27:0];

  // Evaluate an ARM condition code against a {N,Z,C,V} nibble.
  function automatic logic eval_cond(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cf, v;
    n  = f[3];
    z  = f[2];
    cf = f[1];
    v  = f[0];
    case (c)
      4'h0:    eval_cond = z;
      4'h1:    eval_cond = !z;
      4'h2:    eval_cond = cf;
      4'h3:    eval_cond = !cf;
      4'h4:    eval_cond = n;
      4'h5:    eval_cond = !n;
      4'h6:    eval_cond = v;
      4'h7:    eval_cond = !v;
      4'h8:    eval_cond = cf & !z;
      4'h9:    eval_cond = !cf | z;
      4'hA:    eval_cond = (n == v);
      4'hB:    eval_cond = (n != v);
      4'hC:    eval_cond = !z & (n == v);
      4'hD:    eval_cond = z | (n != v);
      4'hE:    eval_cond = 1'b1;
      default: eval_cond = 1'b0;
    endcase
  endfunction

  // Same-cycle bypass: a retiring flag setter is already visible to the
  // request; a same-cycle flag_issue belongs to a younger op and is ignored.
  always_comb begin
    pend_eff = pending;
    if (flag_wr && (pending != '0)) begin
      pend_eff = pending - PEND_W'(1);
    end
    nzcv_eff    = flag_wr ? flags_in[31:28] : nzcv;
    cond_ready  = (pend_eff == '0);
    accept      = cond_valid & cond_ready;
    cond_pass   = eval_cond(cond, nzcv_eff);
    issue_stall = (pending == PEND_MAX);
  end

  // NZCV register, pending counter with saturation and sticky error.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      nzcv    <= '0;
      pending <= '0;
      err     <= 1'b0;
    end else begin
      if (flag_wr) begin
        nzcv <= flags_in[31:28];
      end
      case ({flag_issue, flag_wr})
        2'b10: begin
          if (pending == PEND_MAX) begin
            err <= 1'b1;
          end else begin
            pending <= pending + PEND_W'(1);
          end
        end
        2'b01: begin
          if (pending == '0) begin
            err <= 1'b1;
          end else begin
            pending <= pending - PEND_W'(1);
          end
        end
        default: pending <= pending;
      endcase
    end
  end

  // Request control and registered condition result.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      req_state <= IDLE;
      res_valid <= 1'b0;
      res_pass  <= 1'b0;
    end else begin
      res_valid <= accept;
      if (accept) begin
        res_pass <= cond_pass;
      end
      case (req_state)
        IDLE:    if (cond_valid && !cond_ready) req_state <= WAIT;
        WAIT:    if (accept) req_state <= IDLE;
        default: req_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_flag_unit.sv
// Self-checking bench for alu_flag_unit: directed scenarios plus randomized
// traffic against a behavioural model.
module tb_alu_flag_unit;

  localparam int unsigned PEND_W = 2;
  localparam int PMAX = (1 << PEND_W) - 1;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              flag_issue;
  logic              flag_wr;
  logic [31:0]       flags_in;
  logic              cond_valid;
  logic [3:0]        cond;
  logic              cond_ready;
  logic              res_valid;
  logic              res_pass;
  logic [3:0]        nzcv;
  logic [PEND_W-1:0] pending;
  logic              issue_stall;
  logic              err;

  int n_checks = 0;
  int n_errors = 0;

  // Model state
  logic [3:0] m_nzcv;
  int         m_pend;
  logic       m_rv, m_rp, m_err;

  always #5 clk = ~clk;

  alu_flag_unit #(.PEND_W(PEND_W)) dut (
    .clk(clk), .rst_n(rst_n), .flag_issue(flag_issue), .flag_wr(flag_wr),
    .flags_in(flags_in), .cond_valid(cond_valid), .cond(cond),
    .cond_ready(cond_ready), .res_valid(res_valid), .res_pass(res_pass),
    .nzcv(nzcv), .pending(pending), .issue_stall(issue_stall), .err(err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Even codes test a base predicate, odd codes invert it; E/F are constants.
  function automatic logic ref_eval(input logic [3:0] c, input logic [3:0] f);
    logic base;
    case (c[3:1])
      3'd0: base = f[2];
      3'd1: base = f[1];
      3'd2: base = f[3];
      3'd3: base = f[0];
      3'd4: base = f[1] && !f[2];
      3'd5: base = (f[3] == f[0]);
      3'd6: base = !f[2] && (f[3] == f[0]);
      default: return (c == 4'hE);
    endcase
    return c[0] ? !base : base;
  endfunction

  task automatic idle_inputs();
    flag_issue = 0; flag_wr = 0; flags_in = '0; cond_valid = 0; cond = '0;
  endtask

  // One clock: check combinational outputs, advance model, check registers.
  task automatic cycle();
    int peff, pnext;
    #1;
    peff = m_pend - int'(flag_wr);
    if (peff < 0) peff = 0;
    if (rst_n) begin
      check("cond_ready", cond_ready, peff == 0);
      check("issue_stall", issue_stall, m_pend == PMAX);
    end
    if (!rst_n) begin
      m_nzcv = '0; m_pend = 0; m_rv = 0; m_rp = 0; m_err = 0;
    end else begin
      if (cond_valid && peff == 0) begin
        m_rv = 1;
        m_rp = ref_eval(cond, flag_wr ? flags_in[31:28] : m_nzcv);
      end else begin
        m_rv = 0;
      end
      pnext = m_pend + int'(flag_issue) - int'(flag_wr);
      if (pnext > PMAX) begin pnext = PMAX; m_err = 1; end
      if (pnext < 0)    begin pnext = 0;    m_err = 1; end
      m_pend = pnext;
      if (flag_wr) m_nzcv = flags_in[31:28];
    end
    @(posedge clk); #1;
    check("nzcv", nzcv, m_nzcv);
    check("pending", pending, m_pend);
    check("res_valid", res_valid, m_rv);
    check("res_pass", res_pass, m_rp);
    check("err", err, m_err);
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 0;
    cycle();
    rst_n = 1;
  endtask

  initial begin
    // Reset with random inputs for two edges
    rst_n = 0;
    for (int i = 0; i < 2; i++) begin
      flag_issue = 1'($urandom); flag_wr = 1'($urandom); flags_in = $urandom;
      cond_valid = 1'($urandom); cond = 4'($urandom);
      cycle();
    end
    idle_inputs(); rst_n = 1; #1;
    check("rst nzcv", nzcv, 4'h0);
    check("rst pending", pending, 0);
    check("rst res_valid", res_valid, 0);
    check("rst res_pass", res_pass, 0);
    check("rst err", err, 0);
    check("rst cond_ready", cond_ready, 1);
    check("rst issue_stall", issue_stall, 0);

    // Bypass
    flag_issue = 1; cycle();
    idle_inputs(); flag_wr = 1; flags_in = 32'h4000_0000; cond_valid = 1; cond = 4'h0;
    #1; check("byp ready", cond_ready, 1);
    cycle(); idle_inputs();
    check("byp res_valid", res_valid, 1);
    check("byp res_pass", res_pass, 1);
    check("byp nzcv", nzcv, 4'b0100);
    check("byp pending", pending, 0);

    // Stall until second retire
    flag_issue = 1; cycle(); cycle(); flag_issue = 0;
    cond_valid = 1; cond = 4'hA;
    #1; check("stall ready0", cond_ready, 0);
    cycle();
    flag_wr = 1; flags_in = 32'h0000_0000;
    #1; check("stall ready1", cond_ready, 0);
    cycle();
    flag_wr = 0;
    #1; check("stall ready2", cond_ready, 0);
    cycle();
    flag_wr = 1; flags_in = 32'h9000_0000;
    #1; check("stall ready3", cond_ready, 1);
    cycle(); idle_inputs();
    check("stall res_valid", res_valid, 1);
    check("stall res_pass", res_pass, 1);

    // Back-to-back signed compares with nzcv=1000
    flag_issue = 1; cycle();
    idle_inputs(); flag_wr = 1; flags_in = 32'h8000_0000; cycle();
    idle_inputs(); cond_valid = 1;
    begin
      logic [3:0] codes [4] = '{4'hB, 4'hC, 4'hD, 4'hF};
      logic       exps  [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
      for (int i = 0; i < 4; i++) begin
        cond = codes[i]; cycle();
        check("b2b res_valid", res_valid, 1);
        check("b2b res_pass", res_pass, exps[i]);
      end
    end
    idle_inputs(); cycle();
    check("b2b done", res_valid, 0);

    // Saturation and errors
    do_reset();
    flag_issue = 1; cycle(); cycle(); cycle();
    check("sat pending", pending, 3);
    check("sat stall", issue_stall, 1);
    check("sat err0", err, 0);
    cycle();
    check("sat pending4", pending, 3);
    check("sat err1", err, 1);
    do_reset();
    check("err cleared", err, 0);
    flag_wr = 1; flags_in = 32'h6000_0000; cycle(); idle_inputs();
    check("under err", err, 1);
    check("under nzcv", nzcv, 4'h6);
    check("under pending", pending, 0);

    // Reset during stall
    do_reset();
    flag_issue = 1; cycle(); flag_issue = 0;
    cond_valid = 1; cond = 4'hE; cycle();
    check("rs no accept", res_valid, 0);
    rst_n = 0; cycle(); rst_n = 1; #1;
    check("rs pending", pending, 0);
    check("rs ready", cond_ready, 1);
    check("rs res_valid", res_valid, 0);
    cycle();
    check("rs accept", res_valid, 1);

    // Randomized traffic
    idle_inputs(); do_reset();
    for (int i = 0; i < 400; i++) begin
      rst_n      = ($urandom_range(0, 59) != 0);
      flag_issue = ($urandom_range(0, 2) == 0);
      flag_wr    = ($urandom_range(0, 2) == 0);
      flags_in   = $urandom;
      cond_valid = ($urandom_range(0, 1) == 0);
      cond       = 4'($urandom);
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/alu_flag_unit.md
Name: alu_flag_unit

Overview:
- Consumer end of the ALU flags interface.
- Holds the architectural NZCV status register. The register is written from the ALU 32-bit flags word, with N=bit31, Z=bit30, C=bit29 (carry/invalid), V=bit28.
- Evaluates ARM 4-bit condition codes for issuing instructions through a valid/ready handshake.
- Tracks in-flight flag-setting ops and stalls condition checks until the flags they depend on have retired.
- Sits between issue/decode (conditional execution, branches) and the ALU writeback stage.

Parameters:
PEND_W, 2, width of the in-flight flag-setter counter; max pending = 2^PEND_W-1

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  synchronous active-low reset, sampled on rising edge of clk
flag_issue  input  1  a flag-setting ALU op was dispatched this cycle
flag_wr  input  1  a flag-setting ALU op retires this cycle; flags_in valid
flags_in  input  32  ALU flags word; only bits [31:28] used
cond_valid  input  1  condition-check request valid
cond  input  4  ARM condition code of request
cond_ready  output  1  request accepted this cycle when high with cond_valid
res_valid  output  1  one-cycle pulse: res_pass is the result of an accepted request
res_pass  output  1  condition evaluation result
nzcv  output  4  architectural flags {N,Z,C,V}
pending  output  PEND_W  count of dispatched but unretired flag setters
issue_stall  output  1  pending == max; upstream must not assert flag_issue
err  output  1  sticky protocol-error flag

Behaviour:
- Single clock domain. Reset is synchronous and active-low (rst_n); no asynchronous reset.
- Reset values: nzcv=0000, pending=0, res_valid=0, res_pass=0, err=0.
- Reset mid-operation discards any stalled request and any result due next cycle.
- NZCV register:
  - On flag_wr, nzcv <= flags_in[31:28] at the next edge.
  - Otherwise nzcv holds its value.
- Pending counter:
  - Next value = pending + flag_issue - flag_wr.
  - Simultaneous flag_issue and flag_wr: pending is unchanged. Both are legal at any count.
  - flag_issue alone at max: pending holds at max and err <= 1.
  - flag_wr alone at 0: pending holds at 0, nzcv still updates, and err <= 1.
  - err clears only on reset.
- issue_stall is combinational: pending == 2^PEND_W-1.
- Effective state, used for same-cycle bypass:
  - pend_eff = pending - flag_wr, floored at 0.
  - nzcv_eff = flag_wr ? flags_in[31:28] : nzcv.
- Request ordering:
  - A flag_issue in the same cycle as cond_valid belongs to a younger instruction.
  - It never blocks that request.
- Handshake:
  - cond_ready = (pend_eff == 0), combinational.
  - cond_ready has no dependency on cond_valid.
  - Requester holds cond_valid and cond stable until accepted.
- Accept (cond_valid & cond_ready):
  - Next edge: res_valid <= 1 and res_pass <= eval(cond, nzcv_eff).
  - Latency is 1 cycle. Back-to-back accepts every cycle are allowed.
- No accept: res_valid <= 0, and res_pass holds its last value.
- Condition table:
  - 0 EQ: Z
  - 1 NE: !Z
  - 2 CS: C
  - 3 CC: !C
  - 4 MI: N
  - 5 PL: !N
  - 6 VS: V
  - 7 VC: !V
  - 8 HI: C & !Z
  - 9 LS: !C | Z
  - A GE: N==V
  - B LT: N!=V
  - C GT: !Z & (N==V)
  - D LE: Z | (N!=V)
  - E AL: 1
  - F NV: 0
- Request-side control:
  - Two-state control per request: IDLE/WAIT.
  - WAIT is entered when cond_valid & !cond_ready.
  - WAIT exits to IDLE on accept.
  - WAIT is visible only as cond_ready low; no extra output.

Test Plan:
- Reset: drive rst_n=0 for 2 edges with random inputs -> nzcv=0, pending=0, res_valid=0, res_pass=0, err=0, cond_ready=1, issue_stall=0.
- Bypass:
  - Stimulus: flag_issue at cycle 0. At cycle 1, flag_wr with flags_in=0x4000_0000, plus cond_valid with cond=0 (EQ).
  - Response: cond_ready=1 in cycle 1. Cycle 2: res_valid=1, res_pass=1, nzcv=0100, pending=0.
- Stall:
  - Stimulus: two flag_issue cycles, then cond_valid with cond=A (GE). First flag_wr flags_in=0x0000_0000; two cycles later, second flag_wr flags_in=0x9000_0000.
  - Response: cond_ready=0 until the second flag_wr cycle. Next cycle: res_valid=1, res_pass=1 (N=V=1).
- Back-to-back signed compares:
  - Stimulus: nzcv=1000; requests B (LT), C (GT), D (LE), F (NV) on consecutive cycles.
  - Response: res_valid high 4 cycles; res_pass = 1, 0, 1, 0.
- Saturation and errors (PEND_W=2):
  - 3 flag_issue -> pending=3, issue_stall=1.
  - 4th flag_issue -> pending=3, err=1.
  - After reset, flag_wr with pending=0 -> err=1, nzcv updated.
- Reset during stall: pending=1 and cond_valid held; assert rst_n=0 for 1 edge -> pending=0, cond_ready=1, res_valid=0 in the cycle after reset.
